decoder_scan: RTL and testbench



---
 rtl/decoder_scan.sv | 105 ++++++++++
 tb/tb_decoder_scan.sv | 155 +++++++++++++++
 2 files changed

// File: rtl/decoder_scan.sv
// Binary-to-one-hot strobe driver with direct decode and auto-scan modes, all outputs registered.
// Optional macro DECODER_SCAN_BLANK_EN inserts one blank (all-zero) cycle before each new scan position.
module decoder_scan #(
   parameter int SEL_WIDTH = 2,
   parameter int DWELL     = 4
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    en,
   input  logic                    mode,
   input  logic [SEL_WIDTH-1:0]    sel,
   output logic [2**SEL_WIDTH-1:0] o,
   output logic [SEL_WIDTH-1:0]    idx,
   output logic                    wrap
);

   localparam int N  = 2**SEL_WIDTH;
   localparam int CW = ($clog2(DWELL+1) > 1) ? $clog2(DWELL+1) : 1;
   localparam logic [CW-1:0] DWELL_C = CW'(DWELL);

   typedef enum logic [1:0] {IDLE, DIRECT, SCAN} state_t;

   state_t               state_q;
   logic [N-1:0]         o_q;
   logic [SEL_WIDTH-1:0] idx_q;
   logic                 wrap_q;
   logic [CW-1:0]        cnt_q;
`ifdef DECODER_SCAN_BLANK_EN
   logic                 blank_q;
`endif

   logic [SEL_WIDTH-1:0] idx_d;
   assign idx_d = idx_q + SEL_WIDTH'(1);

   function automatic logic [N-1:0] onehot(input logic [SEL_WIDTH-1:0] s);
      onehot    = '0;
      onehot[s] = 1'b1;
   endfunction

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         o_q     <= '0;
         idx_q   <= '0;
         wrap_q  <= 1'b0;
         cnt_q   <= '0;
`ifdef DECODER_SCAN_BLANK_EN
         blank_q <= 1'b0;
`endif
      end else if (!en) begin
         // idx is kept so a resumed scan continues where it stopped
         state_q <= IDLE;
         o_q     <= '0;
         wrap_q  <= 1'b0;
         cnt_q   <= '0;
`ifdef DECODER_SCAN_BLANK_EN
         blank_q <= 1'b0;
`endif
      end else if (!mode) begin
         state_q <= DIRECT;
         o_q     <= onehot(sel);
         idx_q   <= sel;
         wrap_q  <= 1'b0;
         cnt_q   <= '0;
`ifdef DECODER_SCAN_BLANK_EN
         blank_q <= 1'b0;
`endif
      end else begin
         state_q <= SCAN;
         if (state_q != SCAN) begin
            // entry edge counts as the first dwell cycle of the current idx
            o_q    <= onehot(idx_q);
            cnt_q  <= CW'(1);
            wrap_q <= 1'b0;
`ifdef DECODER_SCAN_BLANK_EN
            blank_q <= 1'b0;
         end else if (blank_q) begin
            idx_q   <= idx_d;
            o_q     <= onehot(idx_d);
            cnt_q   <= CW'(1);
            wrap_q  <= (idx_q == '1);
            blank_q <= 1'b0;
         end else if (cnt_q == DWELL_C) begin
            o_q     <= '0;
            wrap_q  <= 1'b0;
            blank_q <= 1'b1;
`else
         end else if (cnt_q == DWELL_C) begin
            idx_q  <= idx_d;
            o_q    <= onehot(idx_d);
            cnt_q  <= CW'(1);
            wrap_q <= (idx_q == '1);
`endif
         end else begin
            cnt_q  <= cnt_q + CW'(1);
            wrap_q <= 1'b0;
         end
      end
   end

   assign o    = o_q;
   assign idx  = idx_q;
   assign wrap = wrap_q;

endmodule

// File: tb/tb_decoder_scan.sv
// Scoreboard bench for decoder_scan: stimulus pushes model expectations, a monitor pops and compares each cycle.
module tb_decoder_scan;
   localparam int SW = 2;
   localparam int DW = 3;
   localparam int N  = 4;
`ifdef DECODER_SCAN_BLANK_EN
   localparam int BLANKS = 1;
`else
   localparam int BLANKS = 0;
`endif

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          en = 1'b0;
   logic          mode = 1'b0;
   logic [SW-1:0] sel = '0;
   logic [N-1:0]  o;
   logic [SW-1:0] idx;
   logic          wrap;

   decoder_scan #(.SEL_WIDTH(SW), .DWELL(DW)) dut (
      .clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .sel(sel),
      .o(o), .idx(idx), .wrap(wrap)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [N-1:0]  o;
      logic [SW-1:0] idx;
      logic          wrap;
   } resp_t;

   resp_t exp_q[$];
   int    errors = 0;
   int    checks = 0;

   // Reference model: position index, cycles spent in the current position, scanning flag.
   int    m_idx;
   int    m_t;
   bit    m_scan;
   resp_t m_out;

   function automatic logic [N-1:0] hot(input int p);
      return N'(1 << p);
   endfunction

   function void model_reset();
      m_idx = 0; m_t = 0; m_scan = 0; m_out = '0;
   endfunction

   function void model_step(input bit e, input bit md, input int s);
      m_out.wrap = 1'b0;
      if (!e) begin
         m_out.o = '0; m_scan = 0; m_t = 0;
      end else if (!md) begin
         m_idx = s; m_out.o = hot(s); m_scan = 0; m_t = 0;
      end else if (!m_scan) begin
         m_scan = 1; m_t = 1; m_out.o = hot(m_idx);
      end else begin
         m_t++;
         if (m_t == DW + BLANKS + 1) begin
            m_idx = (m_idx + 1) % N;
            m_t = 1;
            m_out.o = hot(m_idx);
            m_out.wrap = (m_idx == 0);
         end else if (BLANKS == 1 && m_t == DW + 1) begin
            m_out.o = '0;
         end
      end
      m_out.idx = SW'(m_idx);
   endfunction

   task automatic drive(input bit e, input bit md, input int s);
      @(negedge clk);
      rst_n = 1'b1; en = e; mode = md; sel = SW'(s);
      model_step(e, md, s);
      exp_q.push_back(m_out);
   endtask

   // Reset asserted between edges must clear outputs before the next edge.
   task automatic async_reset();
      @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      checks++;
      if ({o, idx, wrap} !== '0) begin
         errors++;
         $display("FAIL async_clear o=%b idx=%0d wrap=%b, expected all zero", o, idx, wrap);
      end
      model_reset();
      exp_q.push_back(m_out);
   endtask

   resp_t mon_e, mon_a;
   initial begin
      forever begin
         @(posedge clk);
         #1;
         if (exp_q.size() > 0) begin
            mon_e = exp_q.pop_front();
            mon_a = {o, idx, wrap};
            checks++;
            if (mon_a !== mon_e) begin
               errors++;
               $display("FAIL scoreboard t=%0t o=%b idx=%0d wrap=%b expected o=%b idx=%0d wrap=%b",
                        $time, mon_a.o, mon_a.idx, mon_a.wrap, mon_e.o, mon_e.idx, mon_e.wrap);
            end
         end
      end
   end

   initial begin
      bit r_mode;
      model_reset();
      exp_q.push_back(m_out);

      for (int i = 0; i < N; i++) drive(1, 0, i);
      drive(0, 0, 0);
      drive(0, 0, 1);

      async_reset();
      for (int i = 0; i < 24; i++) drive(1, 1, int'($urandom_range(0, N-1)));

      for (int i = 0; i < 20 && !(m_idx == 2 && m_t == 1); i++) drive(1, 1, 0);
      for (int i = 0; i < 5; i++) drive(0, 1, 3);
      for (int i = 0; i < 10; i++) drive(1, 1, 1);

      async_reset();
      for (int i = 0; i < 10; i++) drive(1, 1, 2);

      drive(1, 0, 3);
      for (int i = 0; i < 16; i++) drive(1, 1, 0);
      drive(1, 0, 1);

      r_mode = 1'b0;
      for (int i = 0; i < 600; i++) begin
         if ($urandom_range(0, 99) == 0) async_reset();
         if ($urandom_range(0, 19) == 0) r_mode = ~r_mode;
         drive($urandom_range(0, 9) != 0, r_mode, int'($urandom_range(0, N-1)));
      end
      drive(0, 0, 0);

      @(negedge clk);
      @(negedge clk);
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL queue_drain left=%0d expected 0", exp_q.size());
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
